qpsk_mod: RTL



---
 rtl/qpsk_mod_if.sv | 21 ++
 rtl/qpsk_mod.sv | 108 ++++++++++
 2 files changed

// File: rtl/qpsk_mod_if.sv
// Word handshake between a data source and the QPSK modulator.
// A word transfers on a rising edge where data_valid and data_ready are both high.
interface qpsk_mod_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/qpsk_mod.sv
// QPSK modulator: serializes accepted words MSB-first into dibits and drives
// each dibit as an axis-aligned I/Q symbol held for SYM_CYCLES clocks.
module qpsk_mod #(
    parameter int DATA_WIDTH = 8,
    parameter int SYM_CYCLES = 4
) (
    input  logic        CLOCK_256,
    input  logic        reset,
    qpsk_mod_if.slave   bus,
    output logic [1:0]  I,
    output logic [1:0]  Q,
    output logic        sym_strobe,
    output logic        busy,
    output logic        fsm_state
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam int NSYM = DATA_WIDTH / 2;
    localparam int SW   = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int CW   = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam logic [SW-1:0] SYM_LAST = SW'(NSYM - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(SYM_CYCLES - 1);

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic [SW-1:0]         sym_cnt, sym_nx;
    logic [CW-1:0]         cyc_cnt, cyc_nx;
    logic                  last_cycle;
    logic                  accept;

    always_ff @(posedge CLOCK_256 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            sym_cnt <= '0;
            cyc_cnt <= '0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            sym_cnt <= sym_nx;
            cyc_cnt <= cyc_nx;
        end
    end

    // Ready comes from registered state only, so the source can never form a loop through it.
    assign last_cycle     = (state == SEND) && (sym_cnt == SYM_LAST) && (cyc_cnt == CYC_LAST);
    assign bus.data_ready = !reset && ((state == IDLE) || last_cycle);
    assign accept         = bus.data_valid && bus.data_ready;

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        sym_nx   = sym_cnt;
        cyc_nx   = cyc_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SEND;
                    shreg_nx = bus.data_in;
                    sym_nx   = '0;
                    cyc_nx   = '0;
                end
            end
            SEND: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nx = '0;
                    if (sym_cnt == SYM_LAST) begin
                        sym_nx = '0;
                        if (accept) begin
                            shreg_nx = bus.data_in;
                        end else begin
                            state_nx = IDLE;
                            shreg_nx = '0;
                        end
                    end else begin
                        sym_nx   = sym_cnt + 1'b1;
                        shreg_nx = shreg << 2;
                    end
                end else begin
                    cyc_nx = cyc_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Gray mapping onto the axes; 2'b10 is never produced on I or Q.
    always_comb begin
        I = 2'b00;
        Q = 2'b00;
        if (state == SEND) begin
            case (shreg[DATA_WIDTH-1 -: 2])
                2'b00: I = 2'b01;
                2'b01: Q = 2'b01;
                2'b11: I = 2'b11;
                2'b10: Q = 2'b11;
                default: begin
                    I = 2'b00;
                    Q = 2'b00;
                end
            endcase
        end
    end

    assign sym_strobe = (state == SEND) && (cyc_cnt == '0);
    assign busy       = (state == SEND);
    assign fsm_state  = state;
endmodule
